// File: rtl/lock_pkg.sv
// Shared types and defaults for the lock access guard.
// Holds the FSM state encoding and the fail counter width helper.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } guard_state_e;

    localparam int unsigned DEF_MAX_FAILS      = 3;
    localparam int unsigned DEF_OPEN_CYCLES    = 50;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 200;
    localparam int unsigned DEF_TMR_W          = 16;

    // Bits needed to hold 0..max_fails inclusive.
    function automatic int unsigned fail_cnt_w(input int unsigned max_fails);
        int unsigned w;
        w = $clog2(max_fails + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT periods.
// done is high whenever the count sits at zero.
module cycle_timer #(
    parameter int unsigned TMR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             cnt_en,
    output logic             done
);

    logic [TMR_W-1:0] cnt_d;
    logic [TMR_W-1:0] cnt_q;

    // Load wins over counting; the count parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/lock_access_guard.sv
// Turns password verdicts into door, lockout and siren drives.
// Optional macro LOCK_MANUAL_CLOSE_EN adds a close_req input.
module lock_access_guard
    import lock_pkg::*;
#(
    parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
    parameter int unsigned OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned TMR_W          = DEF_TMR_W,
    localparam int unsigned FC_W          = fail_cnt_w(MAX_FAILS)
) (
    input  logic            clk,
    input  logic            reset,
`ifdef LOCK_MANUAL_CLOSE_EN
    input  logic            close_req,
`endif
    input  logic            attempt_valid,
    input  logic            unlock,
    input  logic            alarm,
    output logic            door_open,
    output logic            lockout,
    output logic            siren,
    output logic [FC_W-1:0] fail_count,
    output logic            busy
);

    localparam logic [TMR_W-1:0] OPEN_LD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FC_W-1:0]  MAX_FC  = FC_W'(MAX_FAILS);
    localparam logic [FC_W-1:0]  FC_ONE  = FC_W'(1);

    guard_state_e     state_d;
    guard_state_e     state_q;
    logic [FC_W-1:0]  fail_count_d;
    logic [FC_W-1:0]  fail_count_q;
    logic [FC_W-1:0]  fail_inc;
    logic             door_open_d;
    logic             door_open_q;
    logic             lockout_d;
    logic             lockout_q;
    logic             busy_d;
    logic             busy_q;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_cnt_en;
    logic             tmr_done;
    logic             good;

    assign good     = unlock & ~alarm;
    assign fail_inc = fail_count_q + FC_ONE;

    cycle_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .cnt_en   (tmr_cnt_en),
        .done     (tmr_done)
    );

    // Next state, fail count and timer control; attempts only count in IDLE.
    always_comb begin
        state_d      = state_q;
        fail_count_d = fail_count_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_cnt_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (attempt_valid) begin
                    if (good) begin
                        state_d      = OPEN;
                        fail_count_d = '0;
                        tmr_load     = 1'b1;
                        tmr_load_val = OPEN_LD;
                    end else if (fail_inc >= MAX_FC) begin
                        state_d      = LOCKOUT;
                        fail_count_d = MAX_FC;
                        tmr_load     = 1'b1;
                        tmr_load_val = LOCK_LD;
                    end else begin
                        fail_count_d = fail_inc;
                    end
                end
            end
            OPEN: begin
                if (tmr_done) begin
                    state_d = IDLE;
                end else begin
                    tmr_cnt_en = 1'b1;
                end
`ifdef LOCK_MANUAL_CLOSE_EN
                if (close_req) begin
                    state_d = IDLE;
                end
`endif
            end
            LOCKOUT: begin
                if (tmr_done) begin
                    state_d      = IDLE;
                    fail_count_d = '0;
                end else begin
                    tmr_cnt_en = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                fail_count_d = '0;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        door_open_d = (state_d == OPEN);
        lockout_d   = (state_d == LOCKOUT);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            fail_count_q <= '0;
            door_open_q  <= 1'b0;
            lockout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fail_count_q <= fail_count_d;
            door_open_q  <= door_open_d;
            lockout_q    <= lockout_d;
            busy_q       <= busy_d;
        end
    end

    assign door_open  = door_open_q;
    assign lockout    = lockout_q;
    assign siren      = lockout_q;
    assign busy       = busy_q;
    assign fail_count = fail_count_q;

endmodule

// File: doc/lock_access_guard.md
Name: lock_access_guard

Overview:
Downstream consumer of the password lock's per-attempt verdict (unlock/alarm). It turns each sampled attempt into physical actions:
- a timed door-open pulse on success;
- a consecutive-failure count on failure;
- a timed lockout with siren once the failure limit is reached.

It sits between the password comparator and the door relay / siren drivers.

Parameters:
MAX_FAILS, 3, consecutive failed attempts that trigger lockout (>=1)
OPEN_CYCLES, 50, clk cycles door_open stays asserted after a good attempt (>=1)
LOCKOUT_CYCLES, 200, clk cycles lockout/siren stay asserted (>=1)
TMR_W, 16, timer counter width; must hold max(OPEN_CYCLES, LOCKOUT_CYCLES)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset=0 resets on next rising clk edge)
attempt_valid  input  1  one-cycle strobe: unlock/alarm carry a fresh verdict this cycle
unlock  input  1  verdict from password lock: code matched
alarm  input  1  verdict from password lock: code mismatched
door_open  output  1  door relay drive
lockout  output  1  entry blocked
siren  output  1  siren drive
fail_count  output  $clog2(MAX_FAILS+1)  current consecutive failures
busy  output  1  high in OPEN or LOCKOUT; attempts are ignored

Behaviour:
- Reset (reset=0 at clk edge): state=IDLE; door_open, lockout, siren, busy, fail_count and timer all 0. Reset overrides everything, including mid-OPEN or mid-LOCKOUT.
- All outputs are registered.
- FSM states: IDLE, OPEN, LOCKOUT.
- IDLE with attempt_valid=1:
  - Success (unlock=1 & alarm=0): next state OPEN, timer=OPEN_CYCLES-1, fail_count cleared to 0.
  - Failure (any other unlock/alarm combination, including both 1 or both 0): fail_count+1.
    - If the new count == MAX_FAILS: next state LOCKOUT, timer=LOCKOUT_CYCLES-1.
    - Otherwise: stay in IDLE.
- IDLE with attempt_valid=0: hold all state.
- OPEN:
  - door_open=1 and busy=1 starting the cycle after the accepted attempt, for exactly OPEN_CYCLES cycles.
  - The timer decrements each cycle; when timer==0, go to IDLE.
- LOCKOUT:
  - lockout=1, siren=1 and busy=1 for exactly LOCKOUT_CYCLES cycles, starting the cycle after the failing attempt.
  - Exit to IDLE with fail_count cleared to 0.
  - fail_count reads MAX_FAILS while in LOCKOUT.
- attempt_valid in OPEN or LOCKOUT: ignored. No count change, no extension of the current period, no queuing.
- Timing: an attempt on the exit cycle (timer==0) is ignored; an attempt on the first IDLE cycle is accepted.
- Latency: verdict to output change is 1 cycle.
- fail_count saturates at MAX_FAILS and never wraps.

Optional Feature:
LOCK_MANUAL_CLOSE_EN
- Defined: adds input port close_req (1 bit). close_req=1 in OPEN forces IDLE on the next edge, so door_open drops after 1 cycle. close_req has no effect in IDLE or LOCKOUT.
- Undefined: no close_req port; OPEN always lasts the full OPEN_CYCLES.

Decomposition:
- Package lock_pkg:
  - state enum (IDLE, OPEN, LOCKOUT);
  - default constants for MAX_FAILS, OPEN_CYCLES, LOCKOUT_CYCLES;
  - function for the fail_count width.
- Sub-module cycle_timer: loadable down-counter.
  - Ports: clk, reset, load, load_val[TMR_W], cnt_en, done (done=1 when count==0).
  - Instantiated once and shared by OPEN and LOCKOUT.

Test Plan:
- Reset then one good attempt (unlock=1, alarm=0) with OPEN_CYCLES=4 -> door_open=1 for exactly 4 cycles starting 1 cycle later; fail_count=0; busy tracks door_open.
- Two bad attempts (alarm=1), then a good one, MAX_FAILS=3 -> fail_count goes 1, 2, then 0; door opens; no lockout.
- Three bad attempts, LOCKOUT_CYCLES=6 -> lockout=1 and siren=1 for 6 cycles; fail_count=3 during lockout, then 0; a good attempt during lockout is ignored (door_open stays 0).
- unlock=1 & alarm=1 together, and unlock=0 & alarm=0 together -> each counted as a failure (fail_count +1).
- reset=0 in the 2nd cycle of LOCKOUT -> next edge: all outputs 0, state IDLE; a following good attempt opens the door normally.
- With LOCK_MANUAL_CLOSE_EN, close_req=1 in the 2nd cycle of OPEN (OPEN_CYCLES=10) -> door_open=0 from the next cycle; state IDLE.
